lsu_align_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align_unit_if.sv | 26 ++
 rtl/lsu_load_extend.sv | 35 +++
 rtl/lsu_align_unit.sv | 202 ++++++++++++++++++++
 tb/tb_lsu_align_unit.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 codes, FSM states, size decode.
// The ISSUE1/WAIT1 states exist only when LSU_MISALIGN_SPLIT_EN is defined.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE0, ST_WAIT0, ST_ISSUE1, ST_WAIT1, ST_RESP} state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE0, ST_WAIT0, ST_RESP} state_e;
`endif

    // Access size in bytes; funct3[2] only selects sign vs zero extension.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic [2:0] funct3, input int xlen);
        case (funct3)
            LB, LH, LW, LBU, LHU: return 1'b1;
            LD, LWU:              return (xlen == 64);
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align_unit_if.sv
// Word-aligned data memory bus: request/grant address phase, rvalid response phase.
interface lsu_align_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              mem_req_o;
    logic              mem_gnt_i;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [NB-1:0]     mem_be_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/lsu_load_extend.sv
// Combinational load extractor: shifts merged beat data down by the byte offset, then
// sign- or zero-extends the selected size to XLEN.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2*XLEN-1:0] merged_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [2:0]        funct3_i,
    output logic [XLEN-1:0]   data_o
);

    logic [2*XLEN-1:0] shifted;
    logic              msb;
    int                nbits;

    // NOTE: every variable written in always_comb is given a value first so no latch is inferred.
    always_comb begin
        shifted = merged_i >> {off_i, 3'b000};
        nbits   = 8 * int'(size_bytes(funct3_i));
        case (funct3_i[1:0])
            2'b00:   msb = shifted[7];
            2'b01:   msb = shifted[15];
            2'b10:   msb = shifted[31];
            default: msb = shifted[63];
        endcase
        data_o = '0;
        for (int i = 0; i < XLEN; i++) begin
            data_o[i] = (i < nbits) ? shifted[i] : (~funct3_i[2] & msb);
        end
    end

endmodule

// File: rtl/lsu_align_unit.sv
// MEM-stage load/store alignment unit. Define LSU_MISALIGN_SPLIT_EN to sequence word-crossing
// accesses as two bus beats; otherwise any misaligned access is trapped with rsp_err_o.
module lsu_align_unit
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    lsu_align_unit_if.master  mem,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_data_o,
    output logic              rsp_err_o,
    output logic              busy_o
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int BEATS = 2;
`else
    localparam int BEATS = 1;
`endif
    localparam int BE_W = BEATS * NB;
    localparam int WD_W = BEATS * XLEN;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata0_q, rdata0_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [XLEN-1:0]   rdata1_q, rdata1_d;
    logic              split_q, split_d;
    logic              in_split;
`endif

    logic [OFF_W-1:0]  in_off, off_q;
    logic [3:0]        in_size, size_q;
    logic              in_err;
    logic [XLEN-1:0]   in_wdata;
    logic [ADDR_W-1:0] base;
    logic [BE_W-1:0]   be_full;
    logic [WD_W-1:0]   wd_full;
    logic [XLEN-1:0]   load_data;

    // Request decode: legality, trap/split decision and store data trimmed to the access size.
    always_comb begin
        in_off  = req_addr_i[OFF_W-1:0];
        in_size = size_bytes(req_funct3_i);
        in_err  = !funct3_legal(req_funct3_i, XLEN) || (req_we_i && req_funct3_i[2]);
`ifdef LSU_MISALIGN_SPLIT_EN
        in_split = (5'(in_off) + 5'(in_size)) > 5'(NB);
`else
        in_err = in_err || ((in_off & OFF_W'(in_size - 4'd1)) != '0);
`endif
        in_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            in_wdata[i*8 +: 8] = (i < int'(in_size)) ? req_wdata_i[i*8 +: 8] : 8'h00;
        end
    end

    // Byte lanes and store data spanning both beats; beat 1 takes the upper halves.
    always_comb begin
        off_q   = addr_q[OFF_W-1:0];
        size_q  = size_bytes(funct3_q);
        base    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        be_full = ((BE_W'(1) << size_q) - BE_W'(1)) << off_q;
        wd_full = WD_W'(wdata_q) << {off_q, 3'b000};
    end

    lsu_load_extend #(.XLEN(XLEN)) u_load_extend (
`ifdef LSU_MISALIGN_SPLIT_EN
        .merged_i ({rdata1_q, rdata0_q}),
`else
        .merged_i ({{XLEN{1'b0}}, rdata0_q}),
`endif
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        rdata1_d = rdata1_q;
        split_d  = split_q;
`endif
        req_ready_o     = (state_q == ST_IDLE);
        busy_o          = (state_q != ST_IDLE);
        rsp_valid_o     = 1'b0;
        rsp_err_o       = 1'b0;
        rsp_data_o      = '0;
        mem.mem_req_o   = 1'b0;
        mem.mem_we_o    = 1'b0;
        mem.mem_addr_o  = '0;
        mem.mem_be_o    = '0;
        mem.mem_wdata_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i;
                    funct3_d = req_funct3_i;
                    we_d     = req_we_i;
                    wdata_d  = in_wdata;
                    err_d    = in_err;
`ifdef LSU_MISALIGN_SPLIT_EN
                    split_d  = in_split && !in_err;
`endif
                    state_d  = in_err ? ST_RESP : ST_ISSUE0;
                end
            end
            ST_ISSUE0: begin
                mem.mem_req_o   = 1'b1;
                mem.mem_we_o    = we_q;
                mem.mem_addr_o  = base;
                mem.mem_be_o    = be_full[NB-1:0];
                mem.mem_wdata_o = wd_full[XLEN-1:0];
                if (mem.mem_gnt_i) state_d = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (mem.mem_rvalid_i) begin
                    rdata0_d = mem.mem_rdata_i;
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_d  = split_q ? ST_ISSUE1 : ST_RESP;
`else
                    state_d  = ST_RESP;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ISSUE1: begin
                mem.mem_req_o   = 1'b1;
                mem.mem_we_o    = we_q;
                mem.mem_addr_o  = base + ADDR_W'(NB);
                mem.mem_be_o    = be_full[BE_W-1:NB];
                mem.mem_wdata_o = wd_full[WD_W-1:XLEN];
                if (mem.mem_gnt_i) state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (mem.mem_rvalid_i) begin
                    rdata1_d = mem.mem_rdata_i;
                    state_d  = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
                rsp_data_o  = (err_q || we_q) ? '0 : load_data;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every register is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            rdata0_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            rdata1_q <= '0;
            split_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            rdata1_q <= rdata1_d;
            split_q  <= split_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Scoreboard bench for lsu_align_unit (XLEN=32); expectations follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_align_unit;
    import lsu_pkg::*;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_delay;
        int          rvalid_delay;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        longint      t_acc;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'b000;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        busy_o;

    beat_t beat_q[$];
    rsp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    beats_pushed = 0;
    int    beats_granted = 0;

    lsu_align_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) mem_bus ();

    lsu_align_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .mem          (mem_bus),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input logic [31:0] addr, input logic [3:0] be, input logic we,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int gnt_delay, input int rvalid_delay);
        beat_q.push_back('{addr, be, we, wdata, rdata, gnt_delay, rvalid_delay});
        beats_pushed++;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data,
                         input logic exp_err, input int exp_lat, input bit expect_rsp);
        int budget;
        budget = 0;
        @(negedge clk); #1;
        while (!req_ready_o && budget < 50) begin
            @(negedge clk); #1;
            budget++;
        end
        check("ready_before_issue", {63'b0, req_ready_o}, 64'd1);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        @(posedge clk);
        if (expect_rsp) sb_q.push_back('{exp_data, exp_err, exp_lat, longint'($time)});
        #1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_wdata_i = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (sb_q.size() != 0 || beat_q.size() != 0); i++) @(negedge clk);
        check("drain_outstanding", 64'(sb_q.size() + beat_q.size()), 64'd0);
    endtask

    // Memory slave: checks each requested beat every cycle until grant, then answers with rvalid.
    initial begin
        int          wait_cnt;
        bit          rsp_pending;
        int          rsp_cnt;
        logic [31:0] rsp_word;
        wait_cnt    = 0;
        rsp_pending = 1'b0;
        rsp_cnt     = 0;
        rsp_word    = '0;
        mem_bus.mem_gnt_i    = 1'b0;
        mem_bus.mem_rvalid_i = 1'b0;
        mem_bus.mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            mem_bus.mem_gnt_i    = 1'b0;
            mem_bus.mem_rvalid_i = 1'b0;
            if (rsp_pending) begin
                if (rsp_cnt == 0) begin
                    mem_bus.mem_rvalid_i = 1'b1;
                    mem_bus.mem_rdata_i  = rsp_word;
                    rsp_pending = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end else if (mem_bus.mem_req_o) begin
                if (beat_q.size() == 0) begin
                    check("req_without_beat", {63'b0, mem_bus.mem_req_o}, 64'd0);
                end else begin
                    check("beat_addr", 64'(mem_bus.mem_addr_o), 64'(beat_q[0].addr));
                    check("beat_be", 64'(mem_bus.mem_be_o), 64'(beat_q[0].be));
                    check("beat_we", {63'b0, mem_bus.mem_we_o}, {63'b0, beat_q[0].we});
                    if (beat_q[0].we) check("beat_wdata", 64'(mem_bus.mem_wdata_o), 64'(beat_q[0].wdata));
                    if (wait_cnt >= beat_q[0].gnt_delay) begin
                        mem_bus.mem_gnt_i = 1'b1;
                        rsp_pending = 1'b1;
                        rsp_cnt     = beat_q[0].rvalid_delay;
                        rsp_word    = beat_q[0].rdata;
                        void'(beat_q.pop_front());
                        beats_granted++;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid_o cycle.
    initial begin
        rsp_t exp_rsp;
        int   lat;
        forever begin
            @(negedge clk);
            if (rsp_valid_o) begin
                if (sb_q.size() == 0) begin
                    check("rsp_without_request", {63'b0, rsp_valid_o}, 64'd0);
                end else begin
                    exp_rsp = sb_q.pop_front();
                    lat = int'((longint'($time) - 5 - exp_rsp.t_acc) / 10) + 1;
                    check("rsp_data", 64'(rsp_data_o), 64'(exp_rsp.data));
                    check("rsp_err", {63'b0, rsp_err_o}, {63'b0, exp_rsp.err});
                    check("rsp_latency", 64'(lat), 64'(exp_rsp.lat));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          target;
        logic [31:0] rst_addr;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {63'b0, req_ready_o}, 64'd1);
        check("reset_busy", {63'b0, busy_o}, 64'd0);
        check("reset_mem_req", {63'b0, mem_bus.mem_req_o}, 64'd0);
        check("reset_mem_be", 64'(mem_bus.mem_be_o), 64'd0);
        check("reset_rsp_valid", {63'b0, rsp_valid_o}, 64'd0);
        check("reset_rsp_data", 64'(rsp_data_o), 64'd0);
        reset = 1'b0;

        // Byte and half loads within one word
        push_beat(32'h1000, 4'b1000, 1'b0, 32'h0, 32'h80AA55CC, 0, 0);
        issue(1'b0, LB, 32'h1003, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b1);
        drain();
        push_beat(32'h1000, 4'b0010, 1'b0, 32'h0, 32'h80AA55CC, 0, 0);
        issue(1'b0, LB, 32'h1001, 32'h0, 32'h00000055, 1'b0, 3, 1'b1);
        drain();
        push_beat(32'h1000, 4'b1000, 1'b0, 32'h0, 32'h80AA55CC, 0, 0);
        issue(1'b0, LBU, 32'h1003, 32'h0, 32'h00000080, 1'b0, 3, 1'b1);
        drain();
        push_beat(32'h2000, 4'b1100, 1'b0, 32'h0, 32'hBEEF1234, 0, 0);
        issue(1'b0, LHU, 32'h2002, 32'h0, 32'h0000BEEF, 1'b0, 3, 1'b1);
        drain();
        push_beat(32'h2000, 4'b0011, 1'b0, 32'h0, 32'h12348001, 0, 0);
        issue(1'b0, LH, 32'h2000, 32'h0, 32'hFFFF8001, 1'b0, 3, 1'b1);
        drain();

        // Word-crossing load: split into two beats, or trapped
`ifdef LSU_MISALIGN_SPLIT_EN
        push_beat(32'h3000, 4'b1000, 1'b0, 32'h0, 32'h11223344, 0, 0);
        push_beat(32'h3004, 4'b0111, 1'b0, 32'h0, 32'h55667788, 0, 0);
        issue(1'b0, LW, 32'h3003, 32'h0, 32'h66778811, 1'b0, 5, 1'b1);
`else
        issue(1'b0, LW, 32'h3003, 32'h0, 32'h00000000, 1'b1, 1, 1'b1);
`endif
        drain();

        // Misaligned in-word half store with a slow grant
`ifdef LSU_MISALIGN_SPLIT_EN
        push_beat(32'h4000, 4'b0110, 1'b1, 32'h00ABCD00, 32'h0, 3, 0);
        issue(1'b1, LH, 32'h4001, 32'h0000ABCD, 32'h0, 1'b0, 6, 1'b1);
`else
        issue(1'b1, LH, 32'h4001, 32'h0000ABCD, 32'h0, 1'b1, 1, 1'b1);
`endif
        drain();

        // Stores that are aligned in both builds
        push_beat(32'h7000, 4'b1000, 1'b1, 32'h5A000000, 32'h0, 2, 0);
        issue(1'b1, LB, 32'h7003, 32'h0000005A, 32'h0, 1'b0, 5, 1'b1);
        drain();
        push_beat(32'h6000, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0, 0, 0);
        issue(1'b1, LW, 32'h6000, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1'b1);
        drain();

        // Word-crossing half store
`ifdef LSU_MISALIGN_SPLIT_EN
        push_beat(32'h8000, 4'b1000, 1'b1, 32'h34000000, 32'h0, 0, 0);
        push_beat(32'h8004, 4'b0001, 1'b1, 32'h00000012, 32'h0, 0, 0);
        issue(1'b1, LH, 32'h8003, 32'h00001234, 32'h0, 1'b0, 5, 1'b1);
`else
        issue(1'b1, LH, 32'h8003, 32'h00001234, 32'h0, 1'b1, 1, 1'b1);
`endif
        drain();

        // Illegal encodings: no bus traffic, error response
        issue(1'b0, LD, 32'h0000_0010, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        drain();
        issue(1'b0, 3'b111, 32'h0000_0020, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        drain();
        issue(1'b1, LBU, 32'h0000_0030, 32'h000000FF, 32'h0, 1'b1, 1, 1'b1);
        drain();

        // Reset while waiting for the last beat's response; the late rvalid must be ignored
`ifdef LSU_MISALIGN_SPLIT_EN
        push_beat(32'h3000, 4'b1000, 1'b0, 32'h0, 32'h11223344, 0, 0);
        push_beat(32'h3004, 4'b0111, 1'b0, 32'h0, 32'h55667788, 0, 3);
        rst_addr = 32'h3003;
        target   = beats_granted + 2;
`else
        push_beat(32'h5000, 4'b1111, 1'b0, 32'h0, 32'hA5A5A5A5, 0, 3);
        rst_addr = 32'h5000;
        target   = beats_granted + 1;
`endif
        issue(1'b0, LW, rst_addr, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 40 && beats_granted < target; i++) begin
            @(negedge clk); #1;
        end
        check("reset_test_grants", 64'(beats_granted), 64'(target));
        @(negedge clk); #1;
        check("busy_in_wait", {63'b0, busy_o}, 64'd1);
        reset = 1'b1;
        @(negedge clk); #1;
        check("post_reset_ready", {63'b0, req_ready_o}, 64'd1);
        check("post_reset_busy", {63'b0, busy_o}, 64'd0);
        check("post_reset_mem_req", {63'b0, mem_bus.mem_req_o}, 64'd0);
        check("post_reset_rsp_valid", {63'b0, rsp_valid_o}, 64'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("late_rvalid_busy", {63'b0, busy_o}, 64'd0);
        check("late_rvalid_ready", {63'b0, req_ready_o}, 64'd1);

        // Normal operation resumes after reset
        push_beat(32'h9000, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D, 0, 0);
        issue(1'b0, LW, 32'h9000, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        check("beats_granted_total", 64'(beats_granted), 64'(beats_pushed));
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
